seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for a multi-digit common-anode seven-segment display. It holds a tear-free display register of 4-bit codes and rotates through the digits at a programmable rate. Each digit's code and decimal-point bit drive the shared seven-segment decoder's `binaryin`/`decin` inputs, and a one-hot active-low anode select is driven alongside. A guard blanking interval separates digits, and a value/load handshake stages updates so they take effect only at frame boundaries.

---
 rtl/seg_scan_ctrl_if.sv | 26 ++
 rtl/seg_scan_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Bus between a display-value producer and the seven-segment scan controller.
// The producer drives value/dpin/load and controls; the controller drives the decoder/anode side.
interface seg_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      enable;
  logic                      lzb;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dpin;
  logic                      load;
  logic                      ldready;
  logic [3:0]                binaryout;
  logic                      decout;
  logic [NUM_DIGITS-1:0]     anode;
  logic                      frame;

  modport master (
    output enable, lzb, value, dpin, load,
    input  ldready, binaryout, decout, anode, frame
  );

  modport slave (
    input  enable, lzb, value, dpin, load,
    output ldready, binaryout, decout, anode, frame
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller with a staged,
// frame-synchronous display register, guard blanking and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_ctrl_if.slave   bus
);

  localparam int unsigned VW   = 4 * NUM_DIGITS;
  localparam int unsigned IW   = $clog2(NUM_DIGITS);
  localparam int unsigned CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_ctrl: NUM_DIGITS must be in 2..8");
  end
  if (REFRESH_DIV < 1) begin : g_bad_refresh
    $error("seg_scan_ctrl: REFRESH_DIV must be >= 1");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("seg_scan_ctrl: BLANK_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         cnt;
  logic [VW-1:0]         stg_val;
  logic [NUM_DIGITS-1:0] stg_dp;
  logic                  pend;
  logic [VW-1:0]         dsp_val;
  logic [NUM_DIGITS-1:0] dsp_dp;
  logic [3:0]            binaryout_q;
  logic                  decout_q;
  logic [NUM_DIGITS-1:0] anode_q;
  logic                  frame_q;

  state_t                nxt_state;
  logic [IW-1:0]         nxt_idx;
  logic [CW-1:0]         nxt_cnt;
  logic                  boundary;
  logic                  xfer;
  logic                  capture;
  logic [VW-1:0]         nxt_val;
  logic [NUM_DIGITS-1:0] nxt_dp;
  logic [NUM_DIGITS-1:0] sup;
  logic                  all_zero;
  logic [3:0]            nxt_code;
  logic                  nxt_dpb;
  logic [NUM_DIGITS-1:0] nxt_anode;
  logic [3:0]            nxt_bin;
  logic                  nxt_dec;

  logic last_blank;
  logic last_show;
  logic last_idx;

  assign last_blank = (cnt == CW'(BLANK_CYCLES - 1));
  assign last_show  = (cnt == CW'(REFRESH_DIV - 1));
  assign last_idx   = (idx == IW'(NUM_DIGITS - 1));

  // Scan sequencing and frame-boundary detection.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = cnt;
    boundary  = 1'b0;
    if (!bus.enable) begin
      nxt_state = IDLE;
      nxt_idx   = '0;
      nxt_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_state = BLANK;
          nxt_idx   = '0;
          nxt_cnt   = '0;
          boundary  = 1'b1;
        end
        BLANK: begin
          if (last_blank) begin
            nxt_state = SHOW;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + CW'(1);
          end
        end
        SHOW: begin
          if (last_show) begin
            nxt_state = BLANK;
            nxt_cnt   = '0;
            nxt_idx   = last_idx ? '0 : idx + IW'(1);
            boundary  = last_idx;
          end else begin
            nxt_cnt = cnt + CW'(1);
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_idx   = '0;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Staging transfer happens only at frame boundaries or while idle; a
  // transfer always wins over a capture, so the load is taken a cycle later.
  always_comb begin
    xfer    = pend && ((state == IDLE) || boundary);
    capture = bus.load && !pend;
    nxt_val = xfer ? stg_val : dsp_val;
    nxt_dp  = xfer ? stg_dp  : dsp_dp;
  end

  // Leading-zero suppression scanned from the most significant digit down.
  always_comb begin
    all_zero = 1'b1;
    sup      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (nxt_val[4*i +: 4] == 4'd0);
      sup[i]   = bus.lzb && all_zero && (i != 0);
    end
  end

  // Output values for the cycle after the coming edge.
  always_comb begin
    nxt_code  = nxt_val[{nxt_idx, 2'b00} +: 4];
    nxt_dpb   = nxt_dp[nxt_idx];
    nxt_anode = '1;
    if (nxt_state == SHOW) begin
      if (state == SHOW) begin
        nxt_anode = anode_q;
      end else if (!sup[nxt_idx]) begin
        nxt_anode = ~(NUM_DIGITS'(1) << nxt_idx);
      end
    end
    nxt_bin = (nxt_state == IDLE) ? 4'd0 : nxt_code;
    nxt_dec = (nxt_state == IDLE) ? 1'b0 : nxt_dpb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      stg_val     <= '0;
      stg_dp      <= '0;
      pend        <= 1'b0;
      dsp_val     <= '0;
      dsp_dp      <= '0;
      binaryout_q <= 4'd0;
      decout_q    <= 1'b0;
      anode_q     <= '1;
      frame_q     <= 1'b0;
    end else begin
      state       <= nxt_state;
      idx         <= nxt_idx;
      cnt         <= nxt_cnt;
      dsp_val     <= nxt_val;
      dsp_dp      <= nxt_dp;
      binaryout_q <= nxt_bin;
      decout_q    <= nxt_dec;
      anode_q     <= nxt_anode;
      frame_q     <= boundary;
      if (xfer) begin
        pend <= 1'b0;
      end else if (capture) begin
        stg_val <= bus.value;
        stg_dp  <= bus.dpin;
        pend    <= 1'b1;
      end
    end
  end

  assign bus.ldready   = ~pend;
  assign bus.binaryout = binaryout_q;
  assign bus.decout    = decout_q;
  assign bus.anode     = anode_q;
  assign bus.frame     = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: per-cycle expected display outputs are
// queued from the stimulus and popped/compared as the DUT scans.
module tb_seg_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 4;
  localparam int unsigned BC = 2;
  localparam int unsigned DP = BC + RD;

  typedef struct packed {
    logic [ND-1:0] anode;
    logic [3:0]    code;
    logic          dp;
    logic          frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial forever #5 clk = ~clk;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Expected outputs for the first 'count' cycles of a frame, built from the
  // slot layout: BC blank cycles then RD lit cycles per digit.
  task automatic push_slots(input logic [4*ND-1:0] v, input logic [ND-1:0] dp,
                            input logic lz, input int count);
    int   k;
    exp_t e;
    logic s;
    k = 0;
    for (int d = 0; d < int'(ND); d++) begin
      s = lz && (d > 0) && ((v >> (4*d)) == '0);
      for (int c = 0; c < int'(DP); c++) begin
        if (k < count) begin
          e.anode = (c < int'(BC) || s) ? '1 : ~(ND'(1) << d);
          e.code  = v[4*d +: 4];
          e.dp    = dp[d];
          e.frame = (d == 0 && c == 0);
          q.push_back(e);
        end
        k++;
      end
    end
  endtask

  task automatic push_frame(input logic [4*ND-1:0] v, input logic [ND-1:0] dp, input logic lz);
    push_slots(v, dp, lz, ND * DP);
  endtask

  task automatic ticks(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_checks++;
        $error("FAIL %s: observed output with no expected entry queued", tag);
      end else begin
        e = q.pop_front();
        chk(tag, 16'({bus.anode, bus.binaryout, bus.decout, bus.frame}), 16'(e));
      end
    end
  endtask

  task automatic load_once(input logic [4*ND-1:0] v, input logic [ND-1:0] dp, input string tag);
    bus.value = v;
    bus.dpin  = dp;
    bus.load  = 1'b1;
    ticks(tag, 1);
    bus.load  = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.lzb    = 1'b0;
    bus.value  = '0;
    bus.dpin   = '0;
    bus.load   = 1'b0;
    #3;
    chk("rst_anode",   16'(bus.anode), 16'h000F);
    chk("rst_bin",     16'(bus.binaryout), 16'h0);
    chk("rst_dec",     16'(bus.decout), 16'h0);
    chk("rst_frame",   16'(bus.frame), 16'h0);
    chk("rst_ldready", 16'(bus.ldready), 16'h1);

    // Load while idle; transfer to display on the following cycle.
    @(negedge clk);
    rst       = 1'b0;
    bus.value = 16'h4321;
    bus.dpin  = 4'b0100;
    bus.load  = 1'b1;
    @(negedge clk);
    chk("idle_ldready_lo", 16'(bus.ldready), 16'h0);
    bus.load = 1'b0;
    @(negedge clk);
    chk("idle_ldready_hi", 16'(bus.ldready), 16'h1);
    chk("idle_anode",      16'(bus.anode), 16'h000F);
    chk("idle_bin",        16'(bus.binaryout), 16'h0);

    // Basic scan.
    bus.enable = 1'b1;
    push_frame(16'h4321, 4'b0100, 1'b0);
    ticks("scan1", ND * DP);

    // Tear-free update mid-frame; the second load is dropped.
    push_frame(16'h4321, 4'b0100, 1'b0);
    ticks("scan2", 8);
    bus.value = 16'h00AB;
    bus.dpin  = 4'b0001;
    bus.load  = 1'b1;
    ticks("scan2", 1);
    chk("upd_ldready_lo", 16'(bus.ldready), 16'h0);
    bus.value = 16'hFFFF;
    bus.dpin  = 4'b1111;
    ticks("scan2", 3);
    bus.load = 1'b0;
    chk("upd_ldready_hold", 16'(bus.ldready), 16'h0);
    ticks("scan2", 12);

    push_frame(16'h00AB, 4'b0001, 1'b0);
    ticks("upd", 1);
    chk("upd_ldready_hi", 16'(bus.ldready), 16'h1);
    ticks("upd", 3);
    load_once(16'h0050, 4'b1000, "upd");
    ticks("upd", 19);

    // Leading-zero blanking; digit 3's dp bit does not unblank it.
    bus.lzb = 1'b1;
    push_frame(16'h0050, 4'b1000, 1'b1);
    ticks("lzb50", 4);
    load_once(16'h0000, 4'b0000, "lzb50");
    ticks("lzb50", 19);

    push_frame(16'h0000, 4'b0000, 1'b1);
    ticks("lzb0", 4);
    load_once(16'h4321, 4'b0100, "lzb0");
    ticks("lzb0", 19);

    // Disable during digit 2, then re-enable.
    bus.lzb = 1'b0;
    push_slots(16'h4321, 4'b0100, 1'b0, 2 * DP + BC + 2);
    ticks("dis", 2 * DP + BC + 2);
    bus.enable = 1'b0;
    q.push_back('{anode: '1, code: 4'd0, dp: 1'b0, frame: 1'b0});
    q.push_back('{anode: '1, code: 4'd0, dp: 1'b0, frame: 1'b0});
    ticks("dis_idle", 2);
    bus.enable = 1'b1;
    push_slots(16'h4321, 4'b0100, 1'b0, 10);
    ticks("reen", 3);
    load_once(16'h9999, 4'b1111, "reen");
    chk("reen_pend", 16'(bus.ldready), 16'h0);
    ticks("reen", 6);

    // Asynchronous reset between edges while a load is pending.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_anode",   16'(bus.anode), 16'h000F);
    chk("arst_bin",     16'(bus.binaryout), 16'h0);
    chk("arst_dec",     16'(bus.decout), 16'h0);
    chk("arst_frame",   16'(bus.frame), 16'h0);
    chk("arst_ldready", 16'(bus.ldready), 16'h1);
    @(negedge clk);
    rst = 1'b0;

    push_frame(16'h0000, 4'b0000, 1'b0);
    ticks("post_rst", 1);
    chk("post_rst_ldready", 16'(bus.ldready), 16'h1);
    ticks("post_rst", 3);
    load_once(16'h1234, 4'b0000, "post_rst");
    chk("coll_pend", 16'(bus.ldready), 16'h0);
    ticks("post_rst", 17);

    // Load held across a frame-boundary transfer.
    bus.value = 16'h5678;
    bus.dpin  = 4'b0010;
    bus.load  = 1'b1;
    push_frame(16'h1234, 4'b0000, 1'b0);
    ticks("post_rst", 2);
    ticks("coll", 1);
    chk("coll_ldready_xfer", 16'(bus.ldready), 16'h1);
    ticks("coll", 1);
    chk("coll_ldready_cap", 16'(bus.ldready), 16'h0);
    bus.load = 1'b0;
    ticks("coll", ND * DP - 2);

    push_frame(16'h5678, 4'b0010, 1'b0);
    ticks("coll_new", 1);
    chk("coll_new_ldready", 16'(bus.ldready), 16'h1);
    ticks("coll_new", ND * DP - 1);

    chk("queue_empty", 16'(q.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
